pipeline_frame_ctrl: RTL
========================

# pipeline_frame_ctrl

Frame-level sequencer for the grayscale/Sobel image processing pipeline. It holds the pipeline in reset while idle and flushes it before each frame. It latches the output mode at a frame boundary and selects which stream drives the display path: raw Bayer, grayscale, edge magnitude, or thresholded edge. It also masks the row-buffer warm-up rows and reports a per-frame edge-pixel count. It sits between the pipeline outputs and the VGA/SDRAM writer.

## Interface
- IMG_W, 640: grayscale pixels per row; raw rows are 2*IMG_W.
- IMG_H, 480: grayscale rows per frame; raw frames are 2*IMG_H rows.
- WARMUP_ROWS, 2: leading grayscale/edge rows suppressed.
- FLUSH_CYC, 4: cycles oPIPE_RST_N is held low in FLUSH.
- iCLK  in  1  system clock
- iRST  in  1  synchronous, active-low reset
- iSTART  in  1  pulse: arm one frame (ignored unless IDLE)
- iSTOP  in  1  pulse: abort to IDLE
- iCONT  in  1  continuous mode: re-arm after each frame
- iMODE_REQ  in  2  0 raw, 1 gray, 2 edge, 3 edge thresholded
- iTHRESH  in  12  edge threshold
- iX_Cont, iY_Cont  in  16 each  raw Bayer coordinates
- iRAW_DATA/iRAW_DVAL  in  12/1  raw Bayer stream
- iGRAY_DATA/iGRAY_DVAL  in  12/1  grayscale stream
- iEDGE_DATA/iEDGE_DVAL  in  12/1  clamped Sobel magnitude stream
- oPIPE_RST_N  out  1  active-low reset to pipeline
- oDATA/oDVAL  out  12/1  selected output stream
- oMODE  out  2  mode latched for current frame
- oBUSY  out  1  high in any state except IDLE
- oFRAME_DONE  out  1  one-cycle pulse at frame end
- oEDGE_CNT  out  20  edge pixels (> iTHRESH) in last completed frame

## Operation
- States: IDLE, FLUSH, WAIT_SOF, RUN, DONE.
- IDLE:
  - oPIPE_RST_N=0 and oDVAL=0.
  - iSTART goes to FLUSH.
- FLUSH:
  - oPIPE_RST_N=0 for exactly FLUSH_CYC cycles.
  - iMODE_REQ is latched into oMODE on entry.
  - Clears the beat, row and edge counters.
  - Then goes to WAIT_SOF.
- WAIT_SOF:
  - oPIPE_RST_N=1.
  - SOF = iRAW_DVAL & iX_Cont==0 & iY_Cont==0.
  - SOF goes to RUN.
  - A frame already in progress is skipped entirely.
- RUN: forwards the stream selected by oMODE.
  - Beats count toward row length: 2*IMG_W in mode 0, otherwise IMG_W.
  - Row counter increments on the last beat of each row.
  - Modes 1–3: oDVAL is suppressed while row count < WARMUP_ROWS. These rows still count toward the total.
  - Mode 3: oDATA = (iEDGE_DATA > iTHRESH) ? 4095 : 0.
  - Modes 2–3: oEDGE_CNT accumulator increments per unmasked beat with iEDGE_DATA > iTHRESH. It saturates at 2^20−1.
  - Last beat of row IMG_H−1 (2*IMG_H−1 in mode 0) goes to DONE.
- DONE: single cycle.
  - oFRAME_DONE=1.
  - oEDGE_CNT is updated from the accumulator; mode 0 reports 0.
  - Goes to FLUSH if iCONT, else IDLE.
- iSTOP in any state:
  - Next state is IDLE, and oDVAL=0 from the next cycle.
  - oEDGE_CNT is not updated and no oFRAME_DONE pulse occurs.
  - iSTOP wins over a simultaneous iSTART.
- iMODE_REQ/iTHRESH changes outside FLUSH do not affect oMODE. iTHRESH is used live.
- Reset values:
  - Outputs: oPIPE_RST_N=0, oDATA=0, oDVAL=0, oMODE=0, oBUSY=0, oFRAME_DONE=0, oEDGE_CNT=0.
  - State: IDLE.

## Timing
- All outputs are registered.
- oDATA/oDVAL lag the selected input by 1 cycle.
- iSTART at edge n:
  - FLUSH state, with oPIPE_RST_N=0 and oBUSY=1, is visible after edge n+1.
  - oPIPE_RST_N rises after edge n+1+FLUSH_CYC.
- SOF at edge n: RUN is entered after edge n+1. A selected-stream beat on the SOF cycle itself is not forwarded.
- Last beat at edge n:
  - The beat appears on oDATA after edge n+1.
  - oFRAME_DONE and the updated oEDGE_CNT appear after edge n+2.
- Frame-to-frame turnaround in continuous mode is 1 + FLUSH_CYC + 1 cycles plus the wait for SOF.
- Reset asserted mid-frame: state is IDLE after the next edge, with oPIPE_RST_N=0.

## Structure
- pipeline_ctrl_pkg:
  - State enum.
  - Mode constants MODE_RAW/GRAY/EDGE/EDGE_TH.
  - EDGE_CNT_W=20.
  - MAX_PIX=12'd4095.
- Sub-module ctrl_row_counter:
  - Beat and row counters.
  - Row-length select (IMG_W or 2*IMG_W).
  - last_beat and last_row flags.
  - Synchronous clear.
- The FSM, output mux and edge accumulator live in the top.

## Test plan
Benches use IMG_W=8, IMG_H=6, WARMUP_ROWS=2, FLUSH_CYC=4.
- Reset, idle 10 cycles -> oPIPE_RST_N=0, oDVAL=0, oBUSY=0, oEDGE_CNT=0.
- iSTART with mode 1, then SOF and 6×8 gray beats of value 200:
  - oPIPE_RST_N is low for exactly 4 cycles.
  - Exactly 32 oDVAL beats of 200 (rows 0–1 masked).
  - One oFRAME_DONE.
- Mode 3, iTHRESH=100, edge stream where 3 unmasked pixels per row equal 510 and the rest equal 0:
  - Those beats output 4095, the others 0.
  - oEDGE_CNT=12.
- Mode 0 with 16×12 raw beats -> 192 forwarded beats, no masking, oEDGE_CNT=0.
- Same-cycle iSTART and iSTOP, then iSTOP mid-RUN:
  - Stays or returns to IDLE; oDVAL=0 the next cycle.
  - No oFRAME_DONE; oEDGE_CNT unchanged.
- iCONT=1, iMODE_REQ changed 1->2 mid-frame:
  - First frame completes in mode 1.
  - Next frame runs in mode 2 after a second flush.
  - A partially seen frame during WAIT_SOF produces no output.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared state encoding, output-mode codes and widths for the frame controller.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StWaitSof,
    StRun,
    StDone
  } ctrl_state_e;

  localparam logic [1:0] MODE_RAW     = 2'd0;
  localparam logic [1:0] MODE_GRAY    = 2'd1;
  localparam logic [1:0] MODE_EDGE    = 2'd2;
  localparam logic [1:0] MODE_EDGE_TH = 2'd3;

  localparam int unsigned EDGE_CNT_W = 20;
  localparam logic [11:0] MAX_PIX    = 12'd4095;

  // Both edge modes accumulate the edge-pixel count.
  function automatic logic mode_counts_edges(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/pipeline_frame_ctrl_if.sv
// Stream and control bundle between the image pipeline, the frame controller and the writer.
interface pipeline_frame_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic                  start;
  logic                  stop;
  logic                  cont;
  logic [1:0]            mode_req;
  logic [11:0]           thresh;
  logic [15:0]           x_cont;
  logic [15:0]           y_cont;
  logic [11:0]           raw_data;
  logic                  raw_dval;
  logic [11:0]           gray_data;
  logic                  gray_dval;
  logic [11:0]           edge_data;
  logic                  edge_dval;

  logic                  pipe_rst_n;
  logic [11:0]           data;
  logic                  dval;
  logic [1:0]            mode;
  logic                  busy;
  logic                  frame_done;
  logic [EDGE_CNT_W-1:0] edge_cnt;

  modport master (
    output start, stop, cont, mode_req, thresh, x_cont, y_cont,
    output raw_data, raw_dval, gray_data, gray_dval, edge_data, edge_dval,
    input  pipe_rst_n, data, dval, mode, busy, frame_done, edge_cnt
  );

  modport slave (
    input  start, stop, cont, mode_req, thresh, x_cont, y_cont,
    input  raw_data, raw_dval, gray_data, gray_dval, edge_data, edge_dval,
    output pipe_rst_n, data, dval, mode, busy, frame_done, edge_cnt
  );

endinterface

// File: rtl/ctrl_row_counter.sv
// Beat/row position within a frame; raw Bayer rows are twice as long and a frame twice as tall.
module ctrl_row_counter #(
  parameter int unsigned IMG_W       = 640,
  parameter int unsigned IMG_H       = 480,
  parameter int unsigned WARMUP_ROWS = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic advance_i,
  input  logic raw_mode_i,
  output logic last_beat_o,
  output logic last_row_o,
  output logic warmup_o
);

  localparam int unsigned BeatW = $clog2(2 * IMG_W);
  localparam int unsigned RowW  = $clog2(2 * IMG_H);

  logic [BeatW-1:0] beat_q, beat_d, beat_last;
  logic [RowW-1:0]  row_q, row_d, row_last;

  assign beat_last   = raw_mode_i ? BeatW'(2 * IMG_W - 1) : BeatW'(IMG_W - 1);
  assign row_last    = raw_mode_i ? RowW'(2 * IMG_H - 1) : RowW'(IMG_H - 1);
  assign last_beat_o = (beat_q == beat_last);
  assign last_row_o  = (row_q == row_last);
  assign warmup_o    = (row_q < RowW'(WARMUP_ROWS));

  always_comb begin
    beat_d = beat_q;
    row_d  = row_q;
    if (clear_i) begin
      beat_d = '0;
      row_d  = '0;
    end else if (advance_i) begin
      if (last_beat_o) begin
        beat_d = '0;
        row_d  = last_row_o ? '0 : row_q + RowW'(1);
      end else begin
        beat_d = beat_q + BeatW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      beat_q <= '0;
      row_q  <= '0;
    end else begin
      beat_q <= beat_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/pipeline_frame_ctrl.sv
// Frame sequencer: flushes the pipeline, waits for start of frame, forwards the selected stream
// with warm-up rows masked, and reports a per-frame edge-pixel count.
module pipeline_frame_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W       = 640,
  parameter int unsigned IMG_H       = 480,
  parameter int unsigned WARMUP_ROWS = 2,
  parameter int unsigned FLUSH_CYC   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  pipeline_frame_ctrl_if.slave  bus_io
);

  localparam int unsigned FlushW = $clog2(FLUSH_CYC + 1);

  ctrl_state_e           state_q, state_d;
  logic [FlushW-1:0]     flush_q, flush_d;
  logic [1:0]            mode_q, mode_d;

  logic                  sof, run, beat, pass, edge_hit;
  logic                  sel_dval;
  logic [11:0]           sel_data;
  logic                  last_beat, last_row, warmup;

  logic [EDGE_CNT_W-1:0] acc_q, acc_d;
  logic                  pipe_rst_n_q, pipe_rst_n_d;
  logic [11:0]           data_q, data_d;
  logic                  dval_q, dval_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;

  assign sof      = bus_io.raw_dval && (bus_io.x_cont == '0) && (bus_io.y_cont == '0);
  assign run      = (state_q == StRun);
  assign edge_hit = (bus_io.edge_data > bus_io.thresh);
  assign beat     = run && sel_dval;
  assign pass     = beat && !((mode_q != MODE_RAW) && warmup);

  ctrl_row_counter #(
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .WARMUP_ROWS (WARMUP_ROWS)
  ) u_row_counter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (state_q == StFlush),
    .advance_i   (beat),
    .raw_mode_i  (mode_q == MODE_RAW),
    .last_beat_o (last_beat),
    .last_row_o  (last_row),
    .warmup_o    (warmup)
  );

  always_comb begin
    sel_data = '0;
    sel_dval = 1'b0;
    unique case (mode_q)
      MODE_RAW: begin
        sel_data = bus_io.raw_data;
        sel_dval = bus_io.raw_dval;
      end
      MODE_GRAY: begin
        sel_data = bus_io.gray_data;
        sel_dval = bus_io.gray_dval;
      end
      MODE_EDGE: begin
        sel_data = bus_io.edge_data;
        sel_dval = bus_io.edge_dval;
      end
      MODE_EDGE_TH: begin
        sel_data = edge_hit ? MAX_PIX : 12'd0;
        sel_dval = bus_io.edge_dval;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      flush_q <= '0;
      mode_q  <= MODE_RAW;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle:    if (bus_io.start) state_d = StFlush;
      StFlush: begin
        if (flush_q == FlushW'(FLUSH_CYC - 1)) state_d = StWaitSof;
        else flush_d = flush_q + FlushW'(1);
      end
      StWaitSof: if (sof) state_d = StRun;
      StRun:     if (beat && last_beat && last_row) state_d = StDone;
      StDone:    state_d = bus_io.cont ? StFlush : StIdle;
      default:   state_d = StIdle;
    endcase
    if (bus_io.stop) state_d = StIdle;
    // Mode is only sampled as a flush begins so it stays constant for the whole frame.
    if ((state_d == StFlush) && (state_q != StFlush)) begin
      flush_d = '0;
      mode_d  = bus_io.mode_req;
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (state_q == StFlush) begin
      acc_d = '0;
    end else if (pass && mode_counts_edges(mode_q) && edge_hit && (acc_q != '1)) begin
      acc_d = acc_q + EDGE_CNT_W'(1);
    end
    pipe_rst_n_d = !(state_d inside {StIdle, StFlush});
    busy_d       = (state_d != StIdle);
    dval_d       = pass && !bus_io.stop;
    data_d       = pass ? sel_data : data_q;
    done_d       = (state_q == StDone) && !bus_io.stop;
    edge_cnt_d   = edge_cnt_q;
    if (done_d) edge_cnt_d = (mode_q == MODE_RAW) ? '0 : acc_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q        <= '0;
      pipe_rst_n_q <= 1'b0;
      data_q       <= '0;
      dval_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      edge_cnt_q   <= '0;
    end else begin
      acc_q        <= acc_d;
      pipe_rst_n_q <= pipe_rst_n_d;
      data_q       <= data_d;
      dval_q       <= dval_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      edge_cnt_q   <= edge_cnt_d;
    end
  end

  assign bus_io.pipe_rst_n = pipe_rst_n_q;
  assign bus_io.data       = data_q;
  assign bus_io.dval       = dval_q;
  assign bus_io.mode       = mode_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.frame_done = done_q;
  assign bus_io.edge_cnt   = edge_cnt_q;

endmodule
